// File: rtl/krnl_proj_split_hls_deadlock_detector.sv
// Deadlock aggregator for the krnl_proj_split dataflow region: confirms a stable non-zero blocked set.
// Optional KRNL_PROJ_SPLIT_DEADLOCK_TIMESTAMP_EN adds a cycle counter and the deadlock_cycle output.
module krnl_proj_split_hls_deadlock_detector #(
  parameter int unsigned N_MON     = 5,
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned THRESHOLD = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [N_MON-1:0]  monitor_block,
  output logic              deadlock_detected,
  output logic [N_MON-1:0]  deadlock_mask,
  output logic [IDX_W-1:0]  deadlock_idx,
`ifdef KRNL_PROJ_SPLIT_DEADLOCK_TIMESTAMP_EN
  output logic [31:0]       deadlock_cycle,
`endif
  output logic              watching
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESHOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WATCH     = 2'd1,
    CONFIRMED = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [N_MON-1:0]   prev_vec, prev_vec_nxt;
  logic               detected_nxt;
  logic [N_MON-1:0]   mask_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic               watching_nxt;
  logic               confirm_c;

  // Index of the lowest set bit; zero for an all-zero vector.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_MON-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N_MON - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Next-state and next-output logic; clear outranks every transition.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    prev_vec_nxt = prev_vec;
    detected_nxt = deadlock_detected;
    mask_nxt     = deadlock_mask;
    idx_nxt      = deadlock_idx;
    confirm_c    = 1'b0;

    if (clear) begin
      state_nxt    = IDLE;
      cnt_nxt      = '0;
      detected_nxt = 1'b0;
      mask_nxt     = '0;
      idx_nxt      = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable && (monitor_block != '0)) begin
            state_nxt    = WATCH;
            prev_vec_nxt = monitor_block;
            cnt_nxt      = CNT_ONE;
          end
        end
        WATCH: begin
          if (!enable || (monitor_block == '0)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (monitor_block != prev_vec) begin
            // A changed blocked set is progress, so timing restarts.
            prev_vec_nxt = monitor_block;
            cnt_nxt      = CNT_ONE;
          end else if (cnt == CNT_LAST) begin
            state_nxt    = CONFIRMED;
            detected_nxt = 1'b1;
            mask_nxt     = prev_vec;
            idx_nxt      = lowest_idx(prev_vec);
            confirm_c    = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        CONFIRMED: begin
          state_nxt = CONFIRMED;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    watching_nxt = (state_nxt == WATCH);
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      prev_vec          <= '0;
      deadlock_detected <= 1'b0;
      deadlock_mask     <= '0;
      deadlock_idx      <= '0;
      watching          <= 1'b0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      prev_vec          <= prev_vec_nxt;
      deadlock_detected <= detected_nxt;
      deadlock_mask     <= mask_nxt;
      deadlock_idx      <= idx_nxt;
      watching          <= watching_nxt;
    end
  end

`ifdef KRNL_PROJ_SPLIT_DEADLOCK_TIMESTAMP_EN
  logic [31:0] cycle_cnt;
  logic [31:0] cycle_cnt_inc;

  // Edges since reset, counting the current edge; wraps naturally at 2**32.
  assign cycle_cnt_inc = cycle_cnt + 32'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt      <= '0;
      deadlock_cycle <= '0;
    end else begin
      cycle_cnt <= cycle_cnt_inc;
      if (clear) begin
        deadlock_cycle <= '0;
      end else if (confirm_c) begin
        deadlock_cycle <= cycle_cnt_inc;
      end
    end
  end
`else
  logic unused_confirm;
  assign unused_confirm = confirm_c;
`endif

endmodule

// File: tb/tb_krnl_proj_split_hls_deadlock_detector.sv
// Directed bench for krnl_proj_split_hls_deadlock_detector with THRESHOLD=4.
module tb_krnl_proj_split_hls_deadlock_detector;

  localparam int unsigned N_MON = 5;
  localparam int unsigned IDX_W = 3;

  logic             clock;
  logic             reset;
  logic             enable;
  logic             clear;
  logic [N_MON-1:0] monitor_block;
  logic             deadlock_detected;
  logic [N_MON-1:0] deadlock_mask;
  logic [IDX_W-1:0] deadlock_idx;
  logic             watching;
`ifdef KRNL_PROJ_SPLIT_DEADLOCK_TIMESTAMP_EN
  logic [31:0]      deadlock_cycle;
`endif

  int n_vec = 0;
  int n_err = 0;

  krnl_proj_split_hls_deadlock_detector #(
    .N_MON(N_MON), .IDX_W(IDX_W), .THRESHOLD(4), .CNT_W(16)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .clear             (clear),
    .monitor_block     (monitor_block),
    .deadlock_detected (deadlock_detected),
    .deadlock_mask     (deadlock_mask),
    .deadlock_idx      (deadlock_idx),
`ifdef KRNL_PROJ_SPLIT_DEADLOCK_TIMESTAMP_EN
    .deadlock_cycle    (deadlock_cycle),
`endif
    .watching          (watching)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_det"},   32'(deadlock_detected), 32'd0);
    chk({tag, "_mask"},  32'(deadlock_mask),     32'd0);
    chk({tag, "_idx"},   32'(deadlock_idx),      32'd0);
    chk({tag, "_watch"}, 32'(watching),          32'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; monitor_block = '0;
    step(2);
    reset = 1'b0;
    chk_idle_outputs("reset");

    // Basic confirm: 00100 held from edge 1.
    enable = 1'b1; monitor_block = 5'b00100;
    step(1);
    chk("basic_watch_e1", 32'(watching), 32'd1);
    chk("basic_det_e1",   32'(deadlock_detected), 32'd0);
    step(2);
    chk("basic_det_e3",   32'(deadlock_detected), 32'd0);
    step(1);
    chk("basic_det_e4",   32'(deadlock_detected), 32'd1);
    chk("basic_mask",     32'(deadlock_mask), 32'b00100);
    chk("basic_idx",      32'(deadlock_idx), 32'd2);
    chk("basic_watch_e4", 32'(watching), 32'd0);

    // Sticky through idle inputs, then clear.
    enable = 1'b0; monitor_block = '0;
    step(10);
    chk("sticky_det",  32'(deadlock_detected), 32'd1);
    chk("sticky_mask", 32'(deadlock_mask), 32'b00100);
    chk("sticky_idx",  32'(deadlock_idx), 32'd2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk_idle_outputs("clear");

    // Rearm with bit 0.
    enable = 1'b1; monitor_block = 5'b00001;
    step(3);
    chk("rearm_det_e3", 32'(deadlock_detected), 32'd0);
    step(1);
    chk("rearm_det_e4", 32'(deadlock_detected), 32'd1);
    chk("rearm_mask",   32'(deadlock_mask), 32'b00001);
    chk("rearm_idx",    32'(deadlock_idx), 32'd0);
    clear = 1'b1; monitor_block = '0;
    step(1);
    clear = 1'b0;

    // Set change restarts timing.
    monitor_block = 5'b00010;
    step(3);
    monitor_block = 5'b00110;
    step(3);
    chk("chg_det_e6",  32'(deadlock_detected), 32'd0);
    chk("chg_watch_e6", 32'(watching), 32'd1);
    step(1);
    chk("chg_det_e7",  32'(deadlock_detected), 32'd1);
    chk("chg_mask",    32'(deadlock_mask), 32'b00110);
    chk("chg_idx",     32'(deadlock_idx), 32'd1);
    clear = 1'b1; monitor_block = '0;
    step(1);
    clear = 1'b0;

    // Transient release.
    monitor_block = 5'b10000;
    step(3);
    chk("rel_watch_e3", 32'(watching), 32'd1);
    monitor_block = '0;
    step(1);
    chk("rel_watch_e4", 32'(watching), 32'd0);
    monitor_block = 5'b10000;
    step(3);
    chk("rel_det_e7", 32'(deadlock_detected), 32'd0);
    step(1);
    chk("rel_det_e8", 32'(deadlock_detected), 32'd1);
    chk("rel_idx",    32'(deadlock_idx), 32'd4);
    clear = 1'b1; monitor_block = '0;
    step(1);
    clear = 1'b0;

    // Enable gating.
    enable = 1'b0; monitor_block = 5'b11111;
    step(20);
    chk("gate_watch", 32'(watching), 32'd0);
    chk("gate_det",   32'(deadlock_detected), 32'd0);

    // Drop enable mid-WATCH.
    enable = 1'b1;
    step(2);
    chk("drop_watch_on",  32'(watching), 32'd1);
    enable = 1'b0;
    step(1);
    chk("drop_watch_off", 32'(watching), 32'd0);

    // Clear on the would-be confirming edge.
    enable = 1'b1;
    step(3);
    chk("clrpri_det_e3", 32'(deadlock_detected), 32'd0);
    clear = 1'b1;
    step(1);
    chk("clrpri_det_e4",   32'(deadlock_detected), 32'd0);
    chk("clrpri_watch_e4", 32'(watching), 32'd0);
    // Clear with blocked input held: no entry that edge, rearm on the next.
    step(1);
    chk("clrblk_watch", 32'(watching), 32'd0);
    clear = 1'b0;
    step(1);
    chk("rearm_next_watch", 32'(watching), 32'd1);
    monitor_block = '0;
    step(1);

    // Reset while CONFIRMED.
    monitor_block = 5'b01000;
    step(4);
    chk("rst_pre_det", 32'(deadlock_detected), 32'd1);
    chk("rst_pre_idx", 32'(deadlock_idx), 32'd3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    monitor_block = '0;
    chk_idle_outputs("rst_conf");

`ifdef KRNL_PROJ_SPLIT_DEADLOCK_TIMESTAMP_EN
    // Reset edge is cycle 0; block from edge 34 confirms on edge 37.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(33);
    monitor_block = 5'b00100;
    step(4);
    chk("ts_det",   32'(deadlock_detected), 32'd1);
    chk("ts_cycle", deadlock_cycle, 32'd37);
    clear = 1'b1; monitor_block = '0;
    step(1);
    clear = 1'b0;
    chk("ts_clear", deadlock_cycle, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
